// File: rtl/pwm_capture.sv
// Receive side of the PWM link: turns a pwm_in/dir_in pair back into a signed value
// by counting signed high samples over a free-running window of 2**(PWM_IN_SIZE-1) CE ticks.
module pwm_capture #(
    parameter int PWM_IN_SIZE = 10
) (
    input  logic                   clk,
    input  logic                   async_reset_n,
    input  logic                   CE,
    input  logic                   pwm_in,
    input  logic                   dir_in,
    output logic [PWM_IN_SIZE-1:0] data_out,
    output logic                   data_valid,
    output logic                   active
);
    localparam int W  = PWM_IN_SIZE;
    localparam int WW = PWM_IN_SIZE - 1;

    localparam logic [WW-1:0] WIN_LAST = {WW{1'b1}};
    localparam logic [WW-1:0] WIN_ONE  = {{(WW-1){1'b0}}, 1'b1};

    // Clamp a W+1 bit difference into the signed W-bit output range.
    function automatic logic [W-1:0] saturate(input logic [W:0] diff);
        logic [W-1:0] res;
        if ((diff[W] == 1'b0) && (diff[W-1] == 1'b1)) begin
            res = {1'b0, {(W-1){1'b1}}};
        end else if ((diff[W] == 1'b1) && (diff[W-1] == 1'b0)) begin
            res = {1'b1, {(W-1){1'b0}}};
        end else begin
            res = diff[W-1:0];
        end
        return res;
    endfunction

    logic          pwm_meta_q;
    logic          pwm_sync_q;
    logic          dir_meta_q;
    logic          dir_sync_q;

    logic          p_prev_q;
    logic          p_prev_d;
    logic [WW-1:0] win_q;
    logic [WW-1:0] win_d;
    logic [W-1:0]  pos_q;
    logic [W-1:0]  pos_d;
    logic [W-1:0]  neg_q;
    logic [W-1:0]  neg_d;
    logic          edge_q;
    logic          edge_d;

    logic [W-1:0]  data_out_q;
    logic [W-1:0]  data_out_d;
    logic          active_q;
    logic          active_d;
    logic          valid_q;
    logic          valid_d;

    logic          win_last_s;
    logic          pos_inc_s;
    logic          neg_inc_s;
    logic          rise_s;
    logic [W-1:0]  pos_total_s;
    logic [W-1:0]  neg_total_s;
    logic [W:0]    diff_s;

    // Two-flop synchronizers; level and direction share latency so their alignment survives.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            pwm_meta_q <= 1'b0;
            pwm_sync_q <= 1'b0;
            dir_meta_q <= 1'b0;
            dir_sync_q <= 1'b0;
        end else begin
            pwm_meta_q <= pwm_in;
            pwm_sync_q <= pwm_meta_q;
            dir_meta_q <= dir_in;
            dir_sync_q <= dir_meta_q;
        end
    end

    // Per-sample decode and window-inclusive totals.
    always_comb begin
        win_last_s  = CE && (win_q == WIN_LAST);
        pos_inc_s   = pwm_sync_q & ~dir_sync_q;
        neg_inc_s   = pwm_sync_q & dir_sync_q;
        rise_s      = pwm_sync_q & ~p_prev_q;
        pos_total_s = pos_q + {{(W-1){1'b0}}, pos_inc_s};
        neg_total_s = neg_q + {{(W-1){1'b0}}, neg_inc_s};
        diff_s      = {1'b0, pos_total_s} - {1'b0, neg_total_s};
    end

    // Next-state for window counter, accumulators, edge flag and outputs.
    always_comb begin
        win_d      = win_q;
        p_prev_d   = p_prev_q;
        pos_d      = pos_q;
        neg_d      = neg_q;
        edge_d     = edge_q;
        data_out_d = data_out_q;
        active_d   = active_q;
        valid_d    = win_last_s;
        if (CE) begin
            win_d    = win_q + WIN_ONE;
            p_prev_d = pwm_sync_q;
            if (win_last_s) begin
                data_out_d = saturate(diff_s);
                active_d   = edge_q | rise_s;
                pos_d      = {W{1'b0}};
                neg_d      = {W{1'b0}};
                edge_d     = 1'b0;
            end else begin
                pos_d  = pos_total_s;
                neg_d  = neg_total_s;
                edge_d = edge_q | rise_s;
            end
        end else begin
            win_d = win_q;
        end
    end

    // Window and accumulator state.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            win_q    <= {WW{1'b0}};
            p_prev_q <= 1'b0;
            pos_q    <= {W{1'b0}};
            neg_q    <= {W{1'b0}};
            edge_q   <= 1'b0;
        end else begin
            win_q    <= win_d;
            p_prev_q <= p_prev_d;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
            edge_q   <= edge_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            data_out_q <= {W{1'b0}};
            active_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            active_q   <= active_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign active     = active_q;
    assign data_valid = valid_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: recovers a signed 2's-complement value from an incoming PWM `out`/`dir` pair.
- Counts high samples of the PWM input over a free-running window of 2**(PWM_IN_SIZE-1) CE ticks, signed per sample by `dir`.
- Used for loopback checking of motor-drive PWM and for decoding external PWM sources into the pendulum controller.

Parameters:
- PWM_IN_SIZE, 10, width of data_out; window length = 2**(PWM_IN_SIZE-1) CE ticks. Must match the generator it observes.

Ports:
- clk  input  1  system clock
- async_reset_n  input  1  asynchronous active-low reset
- CE  input  1  sample enable; one sample taken per clk edge with CE=1. Must match the generator's CE rate.
- pwm_in  input  1  PWM level, asynchronous to clk
- dir_in  input  1  direction, 1 = negative, asynchronous to clk
- data_out  output  PWM_IN_SIZE  signed recovered value, registered
- data_valid  output  1  one-clk pulse when data_out updates
- active  output  1  1 if any pwm_in rising edge was seen in the last completed window

Behaviour:
- Reset (async_reset_n=0, asynchronous assert, synchronous deassert by the system):
  - data_out=0, data_valid=0, active=0.
  - Synchronizer flops, window counter, pos_cnt, neg_cnt and edge flag all 0.
- Synchronization:
  - pwm_in and dir_in each pass through a 2-flop synchronizer, updated every clk regardless of CE.
  - Sampling uses the synchronized values p_s and d_s.
  - p_s and d_s share the same 2-clk latency, so generator alignment of out/dir is preserved.
- Window counter:
  - win, width PWM_IN_SIZE-1, increments by 1 on each clk with CE=1 and wraps from all 1's to 0.
  - No change when CE=0.
- Per-sample accumulation (CE=1):
  - p_s=1, d_s=0: pos_cnt += 1.
  - p_s=1, d_s=1: neg_cnt += 1.
  - p_s=0: no count.
  - pos_cnt and neg_cnt are PWM_IN_SIZE bits wide; each can reach 2**(PWM_IN_SIZE-1) and must not wrap.
  - A dir change mid-window is handled per sample; no whole-window sign decision.
- Edge flag:
  - Set on a CE=1 sample where p_s=1 and the previous CE sample had p_s=0.
  - Constant-high input yields no edge, so active=0.
- End of window (CE=1 and win = all 1's):
  - The current sample is included in the totals.
  - diff = pos_total - neg_total, computed in PWM_IN_SIZE+1 bits.
  - data_out <= saturate(diff) to [-2**(PWM_IN_SIZE-1), 2**(PWM_IN_SIZE-1)-1].
  - Only the +2**(PWM_IN_SIZE-1) case (constant high, dir=0) saturates, to 2**(PWM_IN_SIZE-1)-1.
  - -2**(PWM_IN_SIZE-1) (constant high, dir=1) is exact.
  - In the same clk: active <= (edge flag OR current-sample edge); pos_cnt, neg_cnt and edge flag clear to 0; data_valid=1 on the following clk only.
- data_out and active hold between windows.
- Latency: data_valid asserts 1 clk after the final CE sample of a window.
- Window phase is free-running and need not align with the generator's period. For a steady input with period = window, the count is phase-independent, ±1 only when an edge coincides with synchronizer metastability.
- The first window after reset may be partial due to synchronizer fill; its result is legal but not checked.
- CE held 0: no counting and no data_valid; all state held.
- Reset mid-window: accumulated counts are discarded; the next window starts at win=0.

Test Plan (PWM_IN_SIZE=10, window = 512 CE ticks; checks from the second window on):
- pwm_in=0, CE=1 constant -> data_out=0, active=0, data_valid exactly every 512 clks, high for 1 clk.
- pwm_in=1, dir_in=0 constant -> data_out=511 (saturated), active=0; with dir_in=1 -> data_out=-512.
- Generator-shaped input: 100 high / 412 low per 512 ticks, dir_in=0 -> data_out=100, active=1; same waveform with dir_in=1 -> data_out=-100.
- Within one window, 200 high samples with dir_in=0, then 50 high with dir_in=1, rest low -> data_out=150.
- CE asserted 1 clk in 4, 300/512 duty, dir_in=1 -> data_out=-300, data_valid every 2048 clks.
- async_reset_n pulsed low at win=250 mid-window -> all outputs 0 immediately (asynchronous), no data_valid until 512 CE ticks after release.
